// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: captures a pattern of up to MAX_LEN bits and shifts it out
// MSB-first, repeating it a programmable number of times with optional idle gaps.
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t r_state, w_state_nxt;

  // r_pat holds the pattern left-aligned so the first bit always sits at the MSB.
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [MAX_LEN-1:0] r_shift, w_shift_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0]   r_reps_left, w_reps_left_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;

  logic r_dout, w_dout_nxt;
  logic r_dout_valid, w_dout_valid_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_cfg_err, w_cfg_err_nxt;

  logic               w_cfg_ok;
  logic [MAX_LEN-1:0] w_aligned;
  logic               w_reload;

  assign w_cfg_ok  = (len != '0) && (len <= LEN_W'(MAX_LEN)) && (reps != '0);
  assign w_aligned = pattern << (LEN_W'(MAX_LEN) - len);

  always_comb begin
    w_state_nxt      = r_state;
    w_pat_nxt        = r_pat;
    w_shift_nxt      = r_shift;
    w_len_nxt        = r_len;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_reps_left_nxt  = r_reps_left;
    w_gap_nxt        = r_gap;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_cfg_err_nxt    = 1'b0;
    w_reload         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (w_cfg_ok) begin
            w_state_nxt      = S_SEND;
            w_pat_nxt        = w_aligned;
            w_shift_nxt      = w_aligned << 1;
            w_len_nxt        = len;
            w_bit_cnt_nxt    = len - LEN_W'(1);
            w_reps_left_nxt  = reps;
            w_gap_nxt        = gap;
            w_dout_nxt       = w_aligned[MAX_LEN-1];
            w_dout_valid_nxt = 1'b1;
            w_busy_nxt       = 1'b1;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_bit_cnt != '0) begin
          w_bit_cnt_nxt    = r_bit_cnt - LEN_W'(1);
          w_dout_nxt       = r_shift[MAX_LEN-1];
          w_shift_nxt      = r_shift << 1;
          w_dout_valid_nxt = 1'b1;
          w_busy_nxt       = 1'b1;
        end else if (r_reps_left == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_reps_left_nxt = r_reps_left - CNT_W'(1);
          if (r_gap != '0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = r_gap;
            w_busy_nxt    = 1'b1;
          end else begin
            w_reload = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_reload = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          w_busy_nxt    = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Start of a further repetition, entered either straight from SEND or at the end of GAP.
    if (w_reload) begin
      w_state_nxt      = S_SEND;
      w_bit_cnt_nxt    = r_len - LEN_W'(1);
      w_dout_nxt       = r_pat[MAX_LEN-1];
      w_shift_nxt      = r_pat << 1;
      w_dout_valid_nxt = 1'b1;
      w_busy_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_shift      <= '0;
      r_len        <= '0;
      r_bit_cnt    <= '0;
      r_reps_left  <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pat        <= w_pat_nxt;
      r_shift      <= w_shift_nxt;
      r_len        <= w_len_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_reps_left  <= w_reps_left_nxt;
      r_gap        <= w_gap_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule
